// File: rtl/pe_inst_seq_if.sv
// pe_inst_seq_if: host program-load / run-control bus and PE instruction output
// for the per-PE instruction sequencer. Loop_Cnt exists only with INST_SEQ_LOOP_EN.
interface pe_inst_seq_if #(
    parameter int unsigned INST_DWIDTH = 72,
    parameter int unsigned INST_AWIDTH = 10
);
    logic                   Host_Wr_En;
    logic [INST_AWIDTH-1:0] Host_Wr_Addr;
    logic [INST_DWIDTH-1:0] Host_Wr_Data;
    logic                   Start;
    logic [INST_AWIDTH-1:0] End_Addr;
`ifdef INST_SEQ_LOOP_EN
    logic [7:0]             Loop_Cnt;
`endif
    logic [INST_DWIDTH-1:0] Inst_Mem_Out;
    logic                   PE_Array_Busy;
    logic                   Done;
    logic                   Wr_Err;

    // Host / testbench side
    modport master (
`ifdef INST_SEQ_LOOP_EN
        output Loop_Cnt,
`endif
        output Host_Wr_En, Host_Wr_Addr, Host_Wr_Data, Start, End_Addr,
        input  Inst_Mem_Out, PE_Array_Busy, Done, Wr_Err
    );

    // Sequencer side
    modport slave (
`ifdef INST_SEQ_LOOP_EN
        input  Loop_Cnt,
`endif
        input  Host_Wr_En, Host_Wr_Addr, Host_Wr_Data, Start, End_Addr,
        output Inst_Mem_Out, PE_Array_Busy, Done, Wr_Err
    );
endinterface

// File: rtl/pe_inst_seq.sv
// pe_inst_seq: per-PE instruction RAM and sequencer. Streams words 0..End_Addr
// on consecutive cycles after Start, then drives DRAIN_CYCLES NOPs and pulses Done.
// Optional feature macro INST_SEQ_LOOP_EN: repeat the program Loop_Cnt+1 times
// back-to-back before a single drain.
module pe_inst_seq #(
    parameter int unsigned INST_DWIDTH  = 72,
    parameter int unsigned INST_AWIDTH  = 10,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    pe_inst_seq_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** INST_AWIDTH;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LOOP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic [INST_DWIDTH-1:0] mem_q [DEPTH];

    state_t                 state_q, state_d;
    logic [INST_AWIDTH-1:0] pc_q, pc_d;
    logic [INST_AWIDTH-1:0] end_q, end_d;
    logic [CNT_W-1:0]       drain_q, drain_d;
    logic [INST_DWIDTH-1:0] inst_q, inst_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wr_err_q, wr_err_d;
`ifdef INST_SEQ_LOOP_EN
    logic [LOOP_W-1:0]      loop_q, loop_d;
`endif

    logic                   wr_ok;

    assign wr_ok = bus.Host_Wr_En && (state_q == IDLE);

    // Program RAM: writes only while idle; no reset, contents survive Reset
    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem_q[bus.Host_Wr_Addr] <= bus.Host_Wr_Data;
        end
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            end_q    <= '0;
            drain_q  <= '0;
            inst_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
`ifdef INST_SEQ_LOOP_EN
            loop_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            end_q    <= end_d;
            drain_q  <= drain_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
`ifdef INST_SEQ_LOOP_EN
            loop_q   <= loop_d;
`endif
        end
    end

    // Next-state and next-output logic; RAM is read asynchronously so a write
    // landing on the same edge is seen one cycle later (read-first behaviour)
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        end_d    = end_q;
        drain_d  = drain_q;
        inst_d   = inst_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wr_err_d = bus.Host_Wr_En && (state_q != IDLE);
`ifdef INST_SEQ_LOOP_EN
        loop_d   = loop_q;
`endif

        case (state_q)
            IDLE: begin
                inst_d = '0;
                busy_d = 1'b0;
                if (bus.Start) begin
                    end_d   = bus.End_Addr;
                    pc_d    = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef INST_SEQ_LOOP_EN
                    loop_d  = bus.Loop_Cnt;
`endif
                end
            end
            RUN: begin
                inst_d = mem_q[pc_q];
                if (pc_q != end_q) begin
                    pc_d = pc_q + INST_AWIDTH'(1);
`ifdef INST_SEQ_LOOP_EN
                end else if (loop_q != '0) begin
                    pc_d   = '0;
                    loop_d = loop_q - LOOP_W'(1);
`endif
                end else begin
                    state_d = DRAIN;
                    drain_d = CNT_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                inst_d = '0;
                if (drain_q == CNT_W'(1)) begin
                    drain_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            default: begin
                inst_d  = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.Inst_Mem_Out  = inst_q;
    assign bus.PE_Array_Busy = busy_q;
    assign bus.Done          = done_q;
    assign bus.Wr_Err        = wr_err_q;

endmodule
